// File: rtl/add8_err_meter_pkg.sv
// add_meter_pkg: shared FSM state type, accumulator width helpers and popcount
// for the approximate-adder error meter.
package add_meter_pkg;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    function automatic int cnt_w(int w);
        return 2 * w + 1;
    endfunction

    function automatic int abs_w(int w);
        return 3 * w + 1;
    endfunction

    function automatic int sq_w(int w);
        return 4 * w + 2;
    endfunction

    function automatic int hd_w(int w);
        return 2 * w + 4;
    endfunction

    function automatic logic [5:0] popcount(logic [31:0] x);
        logic [5:0] n;
        n = '0;
        for (int k = 0; k < 32; k++) n += {5'b0, x[k]};
        return n;
    endfunction

endpackage

// File: rtl/add8_err_meter_accum.sv
// add_err_accum: two-stage error datapath; stage 1 registers diff/|diff|/popcount,
// stage 2 folds valid entries into the five error accumulators.
module add_err_accum
    import add_meter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [W:0]            apx_o,
    input  logic [W:0]            exact,
    output logic [cnt_w(W)-1:0]   err_count,
    output logic [abs_w(W)-1:0]   sum_abs_err,
    output logic [sq_w(W)-1:0]    sum_sq_err,
    output logic [W:0]            max_abs_err,
    output logic [hd_w(W)-1:0]    hd_sum
);

    localparam int OW = W + 1;
    localparam int CW = cnt_w(W);
    localparam int AW = abs_w(W);
    localparam int SW = sq_w(W);
    localparam int HW = hd_w(W);

    logic signed [W+1:0] diff, s1_diff;
    logic [W:0]          mag, s1_abs;
    logic [5:0]          s1_pc;
    logic                s1_v;
    logic [2*W+1:0]      sq;

    // One extra bit keeps the unsigned operands' difference exact as signed.
    assign diff = $signed({1'b0, apx_o}) - $signed({1'b0, exact});
    assign mag  = diff[W+1] ? OW'(-diff) : diff[W:0];
    assign sq   = {{(W+1){1'b0}}, s1_abs} * {{(W+1){1'b0}}, s1_abs};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            s1_v        <= 1'b0;
            s1_diff     <= '0;
            s1_abs      <= '0;
            s1_pc       <= '0;
            err_count   <= '0;
            sum_abs_err <= '0;
            sum_sq_err  <= '0;
            max_abs_err <= '0;
            hd_sum      <= '0;
        end else begin
            s1_v    <= in_valid;
            s1_diff <= diff;
            s1_abs  <= mag;
            s1_pc   <= popcount(32'(apx_o ^ exact));
            if (s1_v) begin
                err_count   <= err_count + CW'(s1_diff != 0);
                sum_abs_err <= sum_abs_err + AW'(s1_abs);
                sum_sq_err  <= sum_sq_err + SW'(sq);
                hd_sum      <= hd_sum + HW'(s1_pc);
                if (s1_abs > max_abs_err) max_abs_err <= s1_abs;
            end
        end
    end

endmodule

// File: rtl/add8_err_meter.sv
// add8_err_meter: sweeps every A/B pair through an external approximate adder
// and accumulates EP/MAE/MSE/WCE/HD error metrics against the exact sum.
module add8_err_meter
    import add_meter_pkg::*;
#(
    parameter int W       = 8,
    parameter int DUT_LAT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [W-1:0]          apx_a,
    output logic [W-1:0]          apx_b,
    input  logic [W:0]            apx_o,
    output logic [cnt_w(W)-1:0]   err_count,
    output logic [abs_w(W)-1:0]   sum_abs_err,
    output logic [sq_w(W)-1:0]    sum_sq_err,
    output logic [W:0]            max_abs_err,
    output logic [hd_w(W)-1:0]    hd_sum
);

    localparam int IW = 2 * W;
    localparam int DW = $clog2(DUT_LAT + 2) + 1;

    state_t          state, state_nx;
    logic [IW-1:0]   idx;
    logic [DW-1:0]   drain_cnt;
    logic [W:0]      ex_pipe [DUT_LAT+1];
    logic [DUT_LAT:0] v_pipe;
    logic            clr, launch, drained;

    assign launch  = state == SWEEP;
    assign drained = drain_cnt == DW'(DUT_LAT + 1);
    assign clr     = start && (state == IDLE || state == DONE);

    always_comb begin
        state_nx = clr ? SWEEP
                 : (launch && &idx) ? DRAIN
                 : (state == DRAIN && drained) ? DONE
                 : state;
        busy = state == SWEEP || state == DRAIN;
        done = state == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // The exact sum rides alongside the vector so it meets apx_o DUT_LAT cycles later.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            drain_cnt <= '0;
            apx_a     <= '0;
            apx_b     <= '0;
            v_pipe    <= '0;
            for (int k = 0; k <= DUT_LAT; k++) ex_pipe[k] <= '0;
        end else begin
            idx        <= clr ? '0 : launch ? idx + IW'(1) : idx;
            drain_cnt  <= state == DRAIN ? drain_cnt + DW'(1) : '0;
            v_pipe[0]  <= launch;
            ex_pipe[0] <= {1'b0, idx[IW-1:W]} + {1'b0, idx[W-1:0]};
            for (int k = 1; k <= DUT_LAT; k++) begin
                v_pipe[k]  <= v_pipe[k-1];
                ex_pipe[k] <= ex_pipe[k-1];
            end
            if (launch) begin
                apx_a <= idx[IW-1:W];
                apx_b <= idx[W-1:0];
            end
        end
    end

    add_err_accum #(.W(W)) u_accum (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .in_valid    (v_pipe[DUT_LAT]),
        .apx_o       (apx_o),
        .exact       (ex_pipe[DUT_LAT]),
        .err_count   (err_count),
        .sum_abs_err (sum_abs_err),
        .sum_sq_err  (sum_sq_err),
        .max_abs_err (max_abs_err),
        .hd_sum      (hd_sum)
    );

endmodule

// File: tb/tb_add8_err_meter.sv
// tb_add8_err_meter: directed checks of the error meter at W=4 against
// combinational and 3-cycle registered adder models.
module tb_add8_err_meter;

    localparam int W = 4;
    localparam int N = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start0, start1;
    logic [1:0] mode;

    logic busy0, done0, busy1, done1;
    logic [W-1:0] a0, b0, a1, b1;
    logic [W:0] o0, o1;
    logic [2*W:0] ec0, ec1;
    logic [3*W:0] sa0, sa1;
    logic [4*W+1:0] ss0, ss1;
    logic [W:0] mx0, mx1;
    logic [2*W+3:0] hd0, hd1;
    logic [W:0] dly [3];
    logic [31:0] m0 [5];
    logic [31:0] m1 [5];

    int total = 0;
    int bad = 0;

    // 0 exact, 1 sum[0] stuck 0, 2 sum[W] stuck 0, 3 sum[1] stuck 1
    function automatic logic [W:0] model(logic [1:0] m, logic [W-1:0] a, logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (m)
            2'd1: s[0] = 1'b0;
            2'd2: s[W] = 1'b0;
            2'd3: s[1] = 1'b1;
            default: ;
        endcase
        return s;
    endfunction

    assign o0 = model(mode, a0, b0);

    always_ff @(posedge clk) begin
        dly[0] <= model(2'd1, a1, b1);
        dly[1] <= dly[0];
        dly[2] <= dly[1];
    end
    assign o1 = dly[2];

    assign m0[0] = 32'(ec0);
    assign m0[1] = 32'(sa0);
    assign m0[2] = 32'(ss0);
    assign m0[3] = 32'(mx0);
    assign m0[4] = 32'(hd0);
    assign m1[0] = 32'(ec1);
    assign m1[1] = 32'(sa1);
    assign m1[2] = 32'(ss1);
    assign m1[3] = 32'(mx1);
    assign m1[4] = 32'(hd1);

    add8_err_meter #(.W(W), .DUT_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .apx_a(a0), .apx_b(b0), .apx_o(o0), .err_count(ec0), .sum_abs_err(sa0),
        .sum_sq_err(ss0), .max_abs_err(mx0), .hd_sum(hd0)
    );

    add8_err_meter #(.W(W), .DUT_LAT(3)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .apx_a(a1), .apx_b(b1), .apx_o(o1), .err_count(ec1), .sum_abs_err(sa1),
        .sum_sq_err(ss1), .max_abs_err(mx1), .hd_sum(hd1)
    );

    typedef logic [31:0] mv_t [5];
    localparam mv_t E_ZERO = '{0, 0, 0, 0, 0};
    localparam mv_t E_LSB  = '{128, 128, 128, 1, 128};
    localparam mv_t E_MSB  = '{120, 1920, 30720, 16, 120};
    localparam mv_t E_POS  = '{128, 256, 512, 2, 128};

    // Cycles are counted from the edge that samples start to the first edge showing done.
    task automatic run(input bit u, input bit hold, output int cyc);
        @(negedge clk);
        if (u) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        if (!hold) begin start0 = 1'b0; start1 = 1'b0; end
        cyc = 0;
        while (!(u ? done1 : done0) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (hold && cyc == N) begin start0 = 1'b0; start1 = 1'b0; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({busy0, done0, a0, b0, busy1, done1} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=0", {busy0, done0, a0, b0, busy1, done1});
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (m0[k] !== 32'd0) begin
                bad++;
                $display("FAIL reset_metric%0d got=%0d exp=0", k, m0[k]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sweep(input string name, input logic [1:0] m, input mv_t e);
        int cyc;
        mode = m;
        run(1'b0, 1'b0, cyc);
        total++;
        if (cyc !== N + 2) begin
            bad++;
            $display("FAIL %s_cycles got=%0d exp=%0d", name, cyc, N + 2);
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (m0[k] !== e[k]) begin
                bad++;
                $display("FAIL %s_metric%0d got=%0d exp=%0d", name, k, m0[k], e[k]);
            end
        end
    endtask

    task automatic test_latency();
        int cyc;
        run(1'b1, 1'b0, cyc);
        total++;
        if (cyc !== N + 5) begin
            bad++;
            $display("FAIL lat3_cycles got=%0d exp=%0d", cyc, N + 5);
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (m1[k] !== E_LSB[k]) begin
                bad++;
                $display("FAIL lat3_metric%0d got=%0d exp=%0d", k, m1[k], E_LSB[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        mode = 2'd1;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (100) @(negedge clk);
        total++;
        if (busy0 !== 1'b1 || ec0 === '0) begin
            bad++;
            $display("FAIL midrst_pre got busy=%b ec=%0d exp busy=1 ec>0", busy0, ec0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({busy0, done0, a0, b0} !== '0) begin
            bad++;
            $display("FAIL midrst_ctrl got=%b exp=0", {busy0, done0, a0, b0});
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (m0[k] !== 32'd0) begin
                bad++;
                $display("FAIL midrst_metric%0d got=%0d exp=0", k, m0[k]);
            end
        end
        test_sweep("after_rst", 2'd1, E_LSB);
    endtask

    task automatic test_back_to_back();
        int cyc;
        mode = 2'd1;
        run(1'b0, 1'b1, cyc);
        total++;
        if (cyc !== N + 2) begin
            bad++;
            $display("FAIL hold_cycles got=%0d exp=%0d", cyc, N + 2);
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (m0[k] !== E_LSB[k]) begin
                bad++;
                $display("FAIL hold_metric%0d got=%0d exp=%0d", k, m0[k], E_LSB[k]);
            end
        end
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        total++;
        if (done0 !== 1'b0 || busy0 !== 1'b1 || ec0 !== '0 || mx0 !== '0) begin
            bad++;
            $display("FAIL restart_clear got done=%b busy=%b ec=%0d mx=%0d exp 0/1/0/0",
                     done0, busy0, ec0, mx0);
        end
        cyc = 0;
        while (!done0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc !== N + 2) begin
            bad++;
            $display("FAIL restart_cycles got=%0d exp=%0d", cyc, N + 2);
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (m0[k] !== E_LSB[k]) begin
                bad++;
                $display("FAIL restart_metric%0d got=%0d exp=%0d", k, m0[k], E_LSB[k]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        mode = 2'd0;
        test_reset();
        test_sweep("exact", 2'd0, E_ZERO);
        test_sweep("lsb0", 2'd1, E_LSB);
        test_sweep("msb0", 2'd2, E_MSB);
        test_sweep("bit1_hi", 2'd3, E_POS);
        test_latency();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
